// File: rtl/cdr_settings.sv
// Shared widths, loop-filter constants and saturation helper for the CDR loop.
// CDR_LOCK_DET_EN (defined at build time) adds the lock detector in cdr_loop.
package cdr_settings;

  localparam int PERIOD_W  = 32;
  localparam int INT_W     = 24;
  localparam int KP        = 16;
  localparam int KI        = 1;
  localparam int INT_SHIFT = 4;
  localparam int LOCK_WIN  = 256;
  localparam int LOCK_TOL  = 8;

  typedef logic [PERIOD_W-1:0]      period_t;
  typedef logic signed [INT_W-1:0]  integ_t;

  localparam period_t NOM_PERIOD = 32'd1000;

  // a + b clamped to the range of a w-bit two's-complement number (w <= 62)
  function automatic longint sat_add(input longint a, input longint b, input int unsigned w);
    longint s;
    longint hi;
    longint lo;
    s  = a + b;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (s > hi)
      return hi;
    else if (s < lo)
      return lo;
    else
      return s;
  endfunction

endpackage

// File: rtl/cdr_loop_bbpd.sv
// Alexander bang-bang phase detector: registers one up/dn decision per data
// transition, one cycle after the sample pair arrives.
module bbpd (
  input  logic clk_sys,
  input  logic rst,
  input  logic sample_valid,
  input  logic data_bit,
  input  logic edge_bit,
  output logic up,
  output logic dn
);

  logic d_prev;
  logic first_flag;
  logic transition;

  // No decision on the first sample after reset: d_prev is not real data yet.
  assign transition = !first_flag && (data_bit != d_prev);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      d_prev     <= 1'b0;
      first_flag <= 1'b1;
      up         <= 1'b0;
      dn         <= 1'b0;
    end else begin
      up <= 1'b0;
      dn <= 1'b0;
      if (sample_valid) begin
        d_prev     <= data_bit;
        first_flag <= 1'b0;
        if (transition) begin
          up <= (edge_bit == data_bit);
          dn <= (edge_bit == d_prev);
        end
      end
    end
  end

endmodule

// File: rtl/cdr_loop.sv
// Digital CDR loop: bang-bang PD feeding a PI filter that sets the RX period code.
// Build with CDR_LOCK_DET_EN defined to add the windowed lock detector and its locked port.
module cdr_loop
  import cdr_settings::*;
#(
  parameter int PERIOD_W  = cdr_settings::PERIOD_W,
  parameter int INT_W     = cdr_settings::INT_W,
  parameter int KP        = cdr_settings::KP,
  parameter int KI        = cdr_settings::KI,
  parameter int INT_SHIFT = cdr_settings::INT_SHIFT,
  parameter int LOCK_WIN  = cdr_settings::LOCK_WIN,
  parameter int LOCK_TOL  = cdr_settings::LOCK_TOL,
  parameter logic [PERIOD_W-1:0] NOM_PERIOD = cdr_settings::NOM_PERIOD
) (
  input  logic                    clk_sys,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic                    data_bit,
  input  logic                    edge_bit,
  output logic                    up,
  output logic                    dn,
  output logic [PERIOD_W-1:0]     period_code,
  output logic                    period_valid,
  output logic signed [INT_W-1:0] integ
`ifdef CDR_LOCK_DET_EN
  ,
  output logic                    locked
`endif
);

  localparam int SUM_W = PERIOD_W + 2;
  localparam logic signed [SUM_W-1:0] NOM_S  = $signed({2'b00, NOM_PERIOD});
  localparam logic signed [SUM_W-1:0] KP_S   = SUM_W'(KP);
  localparam logic signed [SUM_W-1:0] P_MIN  = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] P_MAX  = $signed({2'b00, {PERIOD_W{1'b1}}});

  bbpd u_bbpd (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .sample_valid (sample_valid),
    .data_bit     (data_bit),
    .edge_bit     (edge_bit),
    .up           (up),
    .dn           (dn)
  );

  logic signed [INT_W-1:0] integ_new;
  logic signed [INT_W-1:0] integ_sh;
  logic signed [SUM_W-1:0] sum;
  logic [PERIOD_W-1:0]     period_next;

  // Proportional kick uses the post-update integrator value.
  always_comb begin
    integ_new = INT_W'(sat_add(longint'(integ), up ? -longint'(KI) : longint'(KI), INT_W));
    integ_sh  = integ_new >>> INT_SHIFT;
    sum       = NOM_S + SUM_W'(integ_sh) + (up ? -KP_S : KP_S);
    if (sum < P_MIN)
      period_next = PERIOD_W'(1);
    else if (sum > P_MAX)
      period_next = {PERIOD_W{1'b1}};
    else
      period_next = sum[PERIOD_W-1:0];
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      integ        <= '0;
      period_code  <= NOM_PERIOD;
      period_valid <= 1'b0;
    end else begin
      period_valid <= up | dn;
      if (up | dn) begin
        integ       <= integ_new;
        period_code <= period_next;
      end
    end
  end

`ifdef CDR_LOCK_DET_EN
  localparam int CNT_W  = $clog2(LOCK_WIN);
  localparam int DIFF_W = CNT_W + 2;
  localparam logic signed [DIFF_W-1:0] ONE_S = DIFF_W'(1);
  localparam logic signed [DIFF_W-1:0] TOL_S = DIFF_W'(LOCK_TOL);

  logic [CNT_W-1:0]         dec_cnt;
  logic signed [DIFF_W-1:0] diff;
  logic signed [DIFF_W-1:0] diff_new;
  logic signed [DIFF_W-1:0] diff_abs;
  logic                     win_last;

  always_comb begin
    diff_new = diff + (up ? ONE_S : -ONE_S);
    diff_abs = diff_new[DIFF_W-1] ? -diff_new : diff_new;
    win_last = (dec_cnt == CNT_W'(LOCK_WIN - 1));
  end

  // Verdict is taken on the window's last decision, so it includes that decision.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      dec_cnt <= '0;
      diff    <= '0;
      locked  <= 1'b0;
    end else if (up | dn) begin
      if (win_last) begin
        locked  <= (diff_abs <= TOL_S);
        dec_cnt <= '0;
        diff    <= '0;
      end else begin
        dec_cnt <= dec_cnt + CNT_W'(1);
        diff    <= diff_new;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdr_loop.sv
// Directed self-checking bench for cdr_loop; integrator narrowed to 10 bits so
// saturation is reachable quickly. Define CDR_LOCK_DET_EN to exercise the lock detector.
module tb_cdr_loop;

  localparam int TB_INT_W = 10;

  logic                       clk_sys = 1'b0;
  logic                       rst = 1'b1;
  logic                       sample_valid = 1'b0;
  logic                       data_bit = 1'b0;
  logic                       edge_bit = 1'b0;
  logic                       up;
  logic                       dn;
  logic [31:0]                period_code;
  logic                       period_valid;
  logic signed [TB_INT_W-1:0] integ;
`ifdef CDR_LOCK_DET_EN
  logic                       locked;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic dp = 1'b0;

  always #5 clk_sys = ~clk_sys;

  cdr_loop #(.INT_W(TB_INT_W)) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .sample_valid (sample_valid),
    .data_bit     (data_bit),
    .edge_bit     (edge_bit),
    .up           (up),
    .dn           (dn),
    .period_code  (period_code),
    .period_valid (period_valid),
    .integ        (integ)
`ifdef CDR_LOCK_DET_EN
    ,
    .locked       (locked)
`endif
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst = 1'b0;
    dp = 1'b0;
  endtask

  // one sample; returns at the negedge where the up/dn decision is visible
  task automatic send(input logic d, input logic e);
    @(negedge clk_sys);
    sample_valid = 1'b1;
    data_bit = d;
    edge_bit = e;
    @(negedge clk_sys);
    sample_valid = 1'b0;
    dp = d;
  endtask

  // back-to-back transitions; mode 0 = all dn, 1 = all up, 2 = alternating starting with up.
  // returns once the last decision has reached the filter outputs
  task automatic stream(input int n, input int mode);
    logic d;
    logic want_up;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      d = ~dp;
      want_up = (mode == 1) || (mode == 2 && (i % 2) == 0);
      sample_valid = 1'b1;
      data_bit = d;
      edge_bit = want_up ? d : dp;
      dp = d;
    end
    @(negedge clk_sys);
    sample_valid = 1'b0;
    @(negedge clk_sys);
  endtask

  initial begin
    repeat (3) @(negedge clk_sys);
    rst = 1'b0;
    chk("rst_up", up, 0);
    chk("rst_dn", dn, 0);
    chk("rst_pv", period_valid, 0);
    chk("rst_period", period_code, 1000);
    chk("rst_integ", integ, 0);
`ifdef CDR_LOCK_DET_EN
    chk("rst_locked", locked, 0);
`endif

    send(1'b1, 1'b0);
    chk("first_up", up, 0);
    chk("first_dn", dn, 0);
    tick();
    chk("first_period", period_code, 1000);
    chk("first_pv", period_valid, 0);

    do_reset();
    send(1'b0, 1'b0);
    chk("seed_up", up, 0);
    send(1'b1, 1'b1);
    chk("up1_up", up, 1);
    chk("up1_dn", dn, 0);
    tick();
    chk("up1_integ", integ, -1);
    chk("up1_period", period_code, 983);
    chk("up1_pv", period_valid, 1);
    chk("up1_up_gone", up, 0);

    send(1'b0, 1'b1);
    chk("dn1_dn", dn, 1);
    chk("dn1_up", up, 0);
    tick();
    chk("dn1_integ", integ, 0);
    chk("dn1_period", period_code, 1016);

    send(1'b1, 1'b0);
    chk("dn2_dn", dn, 1);
    tick();
    chk("dn2_integ", integ, 1);
    chk("dn2_period", period_code, 1016);

    send(1'b1, 1'b1);
    chk("notr_up", up, 0);
    chk("notr_dn", dn, 0);
    tick();
    chk("notr_pv", period_valid, 0);
    chk("notr_period", period_code, 1016);

    repeat (5) tick();
    chk("idle_period", period_code, 1016);
    chk("idle_integ", integ, 1);

    stream(20, 0);
    chk("b2b_integ", integ, 21);
    chk("b2b_period", period_code, 1017);

    stream(600, 0);
    chk("satp_integ", integ, 511);
    chk("satp_period", period_code, 1047);

    stream(1, 1);
    chk("satp_up_integ", integ, 510);
    chk("satp_up_period", period_code, 1015);

    stream(1100, 1);
    chk("satn_integ", integ, -512);
    chk("satn_period", period_code, 952);

    stream(1, 0);
    chk("satn_dn_integ", integ, -511);
    chk("satn_dn_period", period_code, 984);

    // reset coinciding with a transition sample
    @(negedge clk_sys);
    rst = 1'b1;
    sample_valid = 1'b1;
    data_bit = ~dp;
    edge_bit = dp;
    @(negedge clk_sys);
    rst = 1'b0;
    sample_valid = 1'b0;
    chk("rsv_up", up, 0);
    chk("rsv_dn", dn, 0);
    chk("rsv_integ", integ, 0);
    chk("rsv_period", period_code, 1000);
    chk("rsv_pv", period_valid, 0);
    dp = 1'b0;
    send(1'b1, 1'b1);
    chk("rsv_rearm_up", up, 0);
    chk("rsv_rearm_dn", dn, 0);
    tick();
    chk("rsv_rearm_period", period_code, 1000);

`ifdef CDR_LOCK_DET_EN
    chk("lock_pre", locked, 0);
    stream(256, 2);
    chk("lock_alt", locked, 1);
    chk("lock_alt_integ", integ, 0);
    chk("lock_alt_period", period_code, 1016);
    stream(255, 1);
    chk("lock_hold", locked, 1);
    stream(1, 1);
    chk("lock_lost", locked, 0);
    chk("lock_lost_integ", integ, -256);
    chk("lock_lost_period", period_code, 968);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
